pe_div20: RTL and testbench

PE_DIV20 -- requirements
Module: pe_div20

---
 rtl/pe_div_pkg.sv | 17 +
 rtl/div_step.sv | 20 ++
 rtl/pe_div20.sv | 118 +++++++++++
 tb/tb_pe_div20.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pe_div_pkg.sv
// Shared widths, divisor constant and FSM encoding for the PE divide-by-20 block.
package pe_div_pkg;

    localparam int unsigned NUM_W   = 38;
    localparam int unsigned QUOT_W  = 34;
    localparam int unsigned DIVISOR = 20;
    localparam int unsigned REM_W   = 6;
    // Partial remainder stays below DIVISOR, so five bits suffice between steps.
    localparam int unsigned PREM_W  = REM_W - 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step against the constant divisor.
module div_step (
    input  logic [pe_div_pkg::PREM_W-1:0] rem_i,
    input  logic                          bit_i,
    output logic [pe_div_pkg::PREM_W-1:0] rem_o,
    output logic                          q_o
);
    import pe_div_pkg::*;

    logic [PREM_W:0] shifted;
    logic [PREM_W:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - (PREM_W + 1)'(DIVISOR);
        q_o     = (shifted >= (PREM_W + 1)'(DIVISOR));
        rem_o   = q_o ? diff[PREM_W-1:0] : shifted[PREM_W-1:0];
    end

endmodule

// File: rtl/pe_div20.sv
// Signed divide-by-20 of a PE-stage numerator: one quotient bit per cycle, C-style
// truncation toward zero, valid/ready handshake on both sides.
module pe_div20 #(
    parameter int unsigned NUM_W  = pe_div_pkg::NUM_W,
    parameter int unsigned QUOT_W = pe_div_pkg::QUOT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [NUM_W-1:0]  num,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [QUOT_W-1:0] quot,
    output logic signed [5:0]        rem,
    output logic                     busy
);
    import pe_div_pkg::*;

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    state_e                   state_q, state_d;
    logic [NUM_W-1:0]         mag_q, mag_d;
    logic [PREM_W-1:0]        prem_q, prem_d;
    logic                     neg_q, neg_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [QUOT_W-1:0] quot_q, quot_d;
    logic signed [REM_W-1:0]  rem_q, rem_d;

    logic [PREM_W-1:0] step_rem;
    logic              step_q;
    logic [QUOT_W-1:0] quot_mag;
    logic [REM_W-1:0]  rem_mag;

    div_step u_div_step (
        .rem_i (prem_q),
        .bit_i (mag_q[NUM_W-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // mag_q doubles as the quotient register: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    assign quot_mag = mag_q[QUOT_W-1:0];
    assign rem_mag  = {1'b0, prem_q};

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        prem_d  = prem_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        if (clr) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        neg_d   = num[NUM_W-1];
                        mag_d   = num[NUM_W-1] ? (~num + NUM_W'(1)) : num;
                        prem_d  = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (cnt_q == CNT_W'(NUM_W)) begin
                        // Final cycle applies the sign to both results.
                        quot_d  = neg_q ? (~quot_mag + QUOT_W'(1)) : quot_mag;
                        rem_d   = neg_q ? (~rem_mag + REM_W'(1)) : rem_mag;
                        state_d = StDone;
                    end else begin
                        mag_d  = {mag_q[NUM_W-2:0], step_q};
                        prem_d = step_rem;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mag_q   <= '0;
            prem_q  <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            prem_q  <= prem_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign quot      = quot_q;
    assign rem       = rem_q;

endmodule

// File: tb/tb_pe_div20.sv
// Directed self-checking bench for pe_div20: latency, signed results, hold, clr and reset.
module tb_pe_div20;

    localparam int NUM_W  = 38;
    localparam int QUOT_W = 34;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clr;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [NUM_W-1:0]  num;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [QUOT_W-1:0] quot;
    logic signed [5:0]        rem;
    logic                     busy;

    int errors = 0;
    int checks = 0;

    pe_div20 #(
        .NUM_W  (NUM_W),
        .QUOT_W (QUOT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept n, expect out_valid exactly 39 edges after the accept edge, optionally
    // stall the consumer for 'hold' cycles while poking in_valid, then hand off.
    task automatic divide(input string tag, input logic signed [63:0] n,
                          input logic signed [63:0] eq, input logic signed [63:0] er,
                          input int hold);
        int early;
        early = 0;
        chk({tag, "_in_ready"}, in_ready, 1);
        num      = NUM_W'(n);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        for (int i = 1; i <= 38; i++) begin
            tick();
            if (out_valid || in_ready) early++;
        end
        chk({tag, "_early"}, early, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_quot"}, quot, eq);
        chk({tag, "_rem"}, rem, er);
        for (int h = 0; h < hold; h++) begin
            in_valid = ((h % 2) == 0);
            num      = NUM_W'(5);
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_quot"}, quot, eq);
            chk({tag, "_hold_rem"}, rem, er);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_handoff_valid"}, out_valid, 0);
        chk({tag, "_handoff_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int stray;
        reset     = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num       = '0;
        #12;
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 1);

        divide("d400", 400, 20, 0, 0);
        divide("dneg41", -41, -2, -1, 0);
        divide("dzero", 0, 0, 0, 0);
        divide("d19", 19, 0, 19, 0);
        divide("dm20", -20, -1, 0, 0);
        divide("dmax", 64'sd137438953471, 64'sd6871947673, 11, 0);
        divide("dmin", -64'sd137438953472, -64'sd6871947673, -12, 0);
        divide("dhold", 400, 20, 0, 10);

        // Abort mid-RUN: back to idle, last result registers untouched.
        num      = NUM_W'(1000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_quot_kept", quot, 20);
        divide("dclr60", 60, 3, 0, 0);

        // Reset mid-RUN discards the operation.
        num      = NUM_W'(400);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #2;
        chk("rrun_busy", busy, 0);
        chk("rrun_quot", quot, 0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid) stray++;
        end
        chk("rrun_no_result", stray, 0);

        // Asynchronous reset while a result is waiting.
        num      = -NUM_W'(41);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (39) tick();
        chk("rdone_valid_before", out_valid, 1);
        chk("rdone_quot_before", quot, -2);
        #2;
        reset = 1'b1;
        #1;
        chk("rdone_valid", out_valid, 0);
        chk("rdone_quot", quot, 0);
        chk("rdone_rem", rem, 0);
        chk("rdone_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rdone_in_ready", in_ready, 1);
        chk("rdone_valid_after", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
